// File: rtl/rf_write_arbiter.sv
// Register-file write port shared by two requesters, with round-robin arbitration.
// After reset, an optional sweep writes zero to x1..x31 before any requester is served.
module rf_write_arbiter #(
    parameter bit INIT_CLEAR = 1'b1,
    parameter int DATA_W     = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr0_valid,
    input  logic [4:0]        wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    output logic              wr0_ready,
    input  logic              wr1_valid,
    input  logic [4:0]        wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    output logic              wr1_ready,
    output logic              rf_RegWrite,
    output logic [4:0]        rf_WriteReg,
    output logic [DATA_W-1:0] rf_WriteData,
    output logic              init_done
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam state_t RESET_STATE = INIT_CLEAR ? ST_INIT : ST_RUN;

    state_t            state_reg, state_next;
    logic [4:0]        sweep_cnt_reg, sweep_cnt_next;
    logic              last_reg, last_next;
    logic              init_done_reg, init_done_next;
    logic              we_reg, we_next;
    logic [4:0]        addr_reg, addr_next;
    logic [DATA_W-1:0] data_reg, data_next;

    logic [1:0]        req_valid;
    logic [4:0]        req_addr [2];
    logic [DATA_W-1:0] req_data [2];
    logic [1:0]        grant;
    logic              serving;
    logic              sel;

    assign req_valid   = {wr1_valid, wr0_valid};
    assign req_addr[0] = wr0_addr;
    assign req_addr[1] = wr1_addr;
    assign req_data[0] = wr0_data;
    assign req_data[1] = wr1_data;

    // init_done_reg also keeps readies low during and just after reset when no sweep runs
    assign serving = init_done_reg && (state_reg == ST_RUN);

    // A requester wins if alone, or on contention if it was not the last winner
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_grant
            assign grant[gi] = serving && req_valid[gi] &&
                               (!req_valid[1-gi] || (last_reg != 1'(gi)));
        end
    endgenerate

    assign sel       = grant[1];
    assign wr0_ready = grant[0];
    assign wr1_ready = grant[1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= RESET_STATE;
            sweep_cnt_reg <= 5'd1;
            last_reg      <= 1'b1;
            init_done_reg <= 1'b0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            data_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            sweep_cnt_reg <= sweep_cnt_next;
            last_reg      <= last_next;
            init_done_reg <= init_done_next;
            we_reg        <= we_next;
            addr_reg      <= addr_next;
            data_reg      <= data_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        sweep_cnt_next = sweep_cnt_reg;
        last_next      = last_reg;
        init_done_next = init_done_reg;
        we_next        = 1'b0;
        addr_next      = addr_reg;
        data_next      = data_reg;
        if (state_reg == ST_INIT) begin
            we_next   = 1'b1;
            addr_next = sweep_cnt_reg;
            data_next = '0;
            // Counter parks at 31 rather than wrapping to x0
            if (sweep_cnt_reg == 5'd31) begin
                state_next     = ST_RUN;
                init_done_next = 1'b1;
            end else begin
                sweep_cnt_next = sweep_cnt_reg + 5'd1;
            end
        end else begin
            init_done_next = 1'b1;
            if (|grant) begin
                we_next   = |req_addr[sel];
                addr_next = req_addr[sel];
                data_next = req_data[sel];
                last_next = sel;
            end
        end
    end

    assign rf_RegWrite  = we_reg;
    assign rf_WriteReg  = addr_reg;
    assign rf_WriteData = data_reg;
    assign init_done    = init_done_reg;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized scoreboard bench for rf_write_arbiter: the stimulus side predicts grants
// and queues expected writes, an independent monitor pops and compares them.
module tb_rf_write_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n = 1'b0;

    logic        v [2];
    logic [4:0]  a [2];
    logic [31:0] d [2];
    bit          pend [2];

    logic        wr0_ready, wr1_ready, rf_RegWrite, init_done;
    logic [4:0]  rf_WriteReg;
    logic [31:0] rf_WriteData;

    logic        b_v0 = 1'b1;
    logic [4:0]  b_a0 = 5'd9;
    logic [31:0] b_d0 = 32'hCAFE_0009;
    logic        b_v1 = 1'b0;
    logic [4:0]  b_a1 = 5'd0;
    logic [31:0] b_d1 = 32'h0;
    logic        b_wr0_ready, b_wr1_ready, b_RegWrite, b_init_done;
    logic [4:0]  b_WriteReg;
    logic [31:0] b_WriteData;

    rf_write_arbiter #(.INIT_CLEAR(1'b1), .DATA_W(32)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .wr0_valid(v[0]), .wr0_addr(a[0]), .wr0_data(d[0]), .wr0_ready(wr0_ready),
        .wr1_valid(v[1]), .wr1_addr(a[1]), .wr1_data(d[1]), .wr1_ready(wr1_ready),
        .rf_RegWrite(rf_RegWrite), .rf_WriteReg(rf_WriteReg), .rf_WriteData(rf_WriteData),
        .init_done(init_done)
    );

    rf_write_arbiter #(.INIT_CLEAR(1'b0), .DATA_W(32)) u_dut_noclr (
        .clock(clock), .reset_n(reset_n),
        .wr0_valid(b_v0), .wr0_addr(b_a0), .wr0_data(b_d0), .wr0_ready(b_wr0_ready),
        .wr1_valid(b_v1), .wr1_addr(b_a1), .wr1_data(b_d1), .wr1_ready(b_wr1_ready),
        .rf_RegWrite(b_RegWrite), .rf_WriteReg(b_WriteReg), .rf_WriteData(b_WriteData),
        .init_done(b_init_done)
    );

    typedef struct {
        int          stamp;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q [$];
    int  n_cmp  = 0;
    int  n_fail = 0;
    int  cyc;
    int  last_win = 1;

    // Rising edges since the most recent reset release
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_sweep();
        for (int k = 1; k <= 31; k++) exp_q.push_back('{k, 5'(k), 32'h0});
    endtask

    task automatic check_reset_outputs();
        chk("rst_RegWrite", rf_RegWrite, 0);
        chk("rst_WriteReg", rf_WriteReg, 0);
        chk("rst_WriteData", rf_WriteData, 0);
        chk("rst_wr0_ready", wr0_ready, 0);
        chk("rst_wr1_ready", wr1_ready, 0);
        chk("rst_init_done", init_done, 0);
    endtask

    // Reference behaviour for the cycle just sampled: who should be accepted
    task automatic eval_cycle();
        bit done_exp;
        int win;
        done_exp = (cyc >= 31);
        win = -1;
        if (done_exp) begin
            if (v[0] && v[1]) win = 1 - last_win;
            else if (v[0])    win = 0;
            else if (v[1])    win = 1;
        end
        chk("init_done", init_done, done_exp);
        chk("wr0_ready", wr0_ready, win == 0);
        chk("wr1_ready", wr1_ready, win == 1);
        if (win >= 0) begin
            if (a[win] != 5'd0) exp_q.push_back('{cyc + 1, a[win], d[win]});
            last_win  = win;
            pend[win] = 1'b0;
        end
    endtask

    // One clock of stimulus: held requests stay put, idle requesters may start a new one
    task automatic cycle(input int p0, input int p1, input int zp);
        @(posedge clock);
        #1;
        for (int r = 0; r < 2; r++) begin
            if (!pend[r]) begin
                int p;
                p = (r == 0) ? p0 : p1;
                a[r] = (int'($urandom_range(99)) < zp) ? 5'd0 : 5'($urandom_range(31, 1));
                d[r] = $urandom;
                if (int'($urandom_range(99)) < p) begin
                    v[r]    = 1'b1;
                    pend[r] = 1'b1;
                end else begin
                    v[r] = 1'b0;
                end
            end
        end
        @(negedge clock);
        eval_cycle();
    endtask

    task automatic hold(input logic [4:0] a0, input logic [31:0] d0,
                        input logic [4:0] a1, input logic [31:0] d1);
        v[0] = 1'b1; a[0] = a0; d[0] = d0; pend[0] = 1'b1;
        v[1] = 1'b1; a[1] = a1; d[1] = d1; pend[1] = 1'b1;
    endtask

    task automatic assert_reset();
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        last_win = 1;
        #1;
        check_reset_outputs();
    endtask

    task automatic release_reset();
        @(negedge clock);
        #2;
        reset_n = 1'b1;
        push_sweep();
    endtask

    // Monitor: every register-file write must match the oldest expectation and its cycle
    always @(negedge clock) begin
        if (reset_n) begin
            while (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
                n_cmp++;
                n_fail++;
                $display("FAIL missed_write @cyc %0d: got no write, expected x%0d <= %08h at cyc %0d",
                         cyc, exp_q[0].addr, exp_q[0].data, exp_q[0].stamp);
                void'(exp_q.pop_front());
            end
            if (rf_RegWrite) begin
                n_cmp++;
                if (exp_q.size() > 0 && exp_q[0].stamp == cyc) begin
                    if (rf_WriteReg !== exp_q[0].addr || rf_WriteData !== exp_q[0].data) begin
                        n_fail++;
                        $display("FAIL write_value @cyc %0d: got x%0d <= %08h, expected x%0d <= %08h",
                                 cyc, rf_WriteReg, rf_WriteData, exp_q[0].addr, exp_q[0].data);
                    end else begin
                        $display("cyc %0d: write x%0d <= %08h", cyc, rf_WriteReg, rf_WriteData);
                    end
                    void'(exp_q.pop_front());
                end else begin
                    n_fail++;
                    $display("FAIL spurious_write @cyc %0d: got x%0d <= %08h, expected no write",
                             cyc, rf_WriteReg, rf_WriteData);
                end
            end
        end
    end

    // Sweep-less instance: served on the first cycle after release
    initial begin
        @(posedge reset_n);
        @(negedge clock);
        chk("noclr_init_done", b_init_done, 1);
        chk("noclr_wr0_ready", b_wr0_ready, 1);
        @(posedge clock);
        #1 b_v0 = 1'b0;
        @(negedge clock);
        chk("noclr_RegWrite", b_RegWrite, 1);
        chk("noclr_WriteReg", b_WriteReg, 9);
        chk("noclr_WriteData", b_WriteData, 32'hCAFE_0009);
        chk("noclr_wr0_ready_idle", b_wr0_ready, 0);
    end

    initial begin
        hold(5'd5, 32'hDEAD_BEEF, 5'd6, 32'h1234_5678);
        #3;
        check_reset_outputs();
        chk("noclr_rst_init_done", b_init_done, 0);
        chk("noclr_rst_wr0_ready", b_wr0_ready, 0);
        repeat (2) @(posedge clock);
        release_reset();

        // Sweep with both requests held, then x5 and x6 in order
        repeat (33) cycle(0, 0, 0);

        // Continuous contention: grants must alternate
        repeat (6) cycle(100, 100, 0);
        repeat (2) cycle(0, 0, 0);

        // Write to x0 is accepted but suppressed
        v[1] = 1'b1; a[1] = 5'd0; d[1] = 32'hFFFF_FFFF; pend[1] = 1'b1;
        repeat (3) cycle(0, 0, 0);

        repeat (400) cycle(40, 40, 12);
        repeat (3) cycle(0, 0, 0);

        // Reset from RUN, then again in the middle of the sweep
        hold(5'd7, 32'hA5A5_0007, 5'd8, 32'h5A5A_0008);
        assert_reset();
        repeat (2) @(posedge clock);
        release_reset();
        repeat (16) cycle(0, 0, 0);
        assert_reset();
        repeat (2) @(posedge clock);
        release_reset();
        repeat (36) cycle(0, 0, 0);

        @(negedge clock);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
